// File: rtl/stepcmd_queue.sv
// stepcmd_queue: wishbone-staged step-command FIFO feeding the scheduler.
// Commands are {dir, interval, count, add}; head falls through to mq_data.
module stepcmd_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [64:0] mq_data,
  output logic        mq_avail,
  input  logic        mq_pull,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o
);

  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef logic [64:0] cmd_t;

  logic          wr;
  logic          rd;
  logic          do_flush;
  logic          do_push;
  logic          do_clr;
  logic          pull_ok;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic [4:0]    lvl5;
  cmd_t          push_cmd;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   pcnt_q, pcnt_d;
  logic [31:0]   st_int_q, st_int_d;
  logic [15:0]   st_cnt_q, st_cnt_d;
  logic [15:0]   st_add_q, st_add_d;
  cmd_t          mem_q [DEPTH];

  assign wr       = wb_cyc_i & wb_stb_i & wb_we_i;
  assign rd       = wb_cyc_i & wb_stb_i & ~wb_we_i;
  assign do_flush = wr && (wb_adr_i == 4'd0);
  assign do_push  = wr && (wb_adr_i == 4'd3);
  assign do_clr   = wr && (wb_adr_i == 4'd4);

  assign full  = (lvl_q == FULL_LVL);
  assign empty = (lvl_q == '0);
  assign lvl5  = 5'(lvl_q);

  // Flush wins over a same-cycle pull, matching the scheduler.
  assign pull_ok = mq_pull & ~empty & ~do_flush;
  // A pull frees a slot in the same cycle, so full+pull still accepts.
  assign push_ok = do_push & (~full | pull_ok);

  assign push_cmd = {wb_dat_i[0], st_int_q, st_cnt_q, st_add_q};

  assign mq_avail = ~empty;
  assign mq_data  = empty ? '0 : mem_q[rptr_q];
  assign wb_ack_o = 1'b1;

  // Next-state for pointers, level, flags, counter and staging.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    lvl_d    = lvl_q;
    ovf_d    = ovf_q;
    pcnt_d   = pcnt_q;
    st_int_d = st_int_q;
    st_cnt_d = st_cnt_q;
    st_add_d = st_add_q;
    if (do_flush) begin
      rptr_d = wptr_q;
      lvl_d  = '0;
    end else begin
      if (push_ok) begin
        wptr_d = wptr_q + 1'b1;
        pcnt_d = pcnt_q + 16'd1;
      end
      if (pull_ok) begin
        rptr_d = rptr_q + 1'b1;
      end
      unique case ({push_ok, pull_ok})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
    if (do_push && !push_ok) begin
      ovf_d = 1'b1;
    end
    if (do_clr) begin
      ovf_d = 1'b0;
    end
    if (wr && wb_adr_i == 4'd1) begin
      st_int_d = wb_dat_i;
    end
    if (wr && wb_adr_i == 4'd2) begin
      st_cnt_d = wb_dat_i[31:16];
      st_add_d = wb_dat_i[15:0];
    end
  end

  // Control and staging registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      pcnt_q   <= '0;
      st_int_q <= '0;
      st_cnt_q <= '0;
      st_add_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      lvl_q    <= lvl_d;
      ovf_q    <= ovf_d;
      pcnt_q   <= pcnt_d;
      st_int_q <= st_int_d;
      st_cnt_q <= st_cnt_d;
      st_add_q <= st_add_d;
    end
  end

  // Entry storage; written only by an accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wptr_q] <= push_cmd;
    end
  end

  // Side-effect-free register read mux.
  always_comb begin
    wb_dat_o = '0;
    if (rd) begin
      case (wb_adr_i)
        4'd1:    wb_dat_o = st_int_q;
        4'd2:    wb_dat_o = {st_cnt_q, st_add_q};
        4'd4:    wb_dat_o = {15'b0, ovf_q, 6'b0, empty, full,
                             3'b0, lvl5};
        4'd5:    wb_dat_o = {16'b0, pcnt_q};
        default: wb_dat_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_stepcmd_queue.sv
// tb_stepcmd_queue: scoreboard bench for stepcmd_queue.
// Reference model is a plain queue plus staging/flag variables.
module tb_stepcmd_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [64:0] mq_data;
  logic        mq_avail;
  logic        mq_pull;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  stepcmd_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mq_data  (mq_data),
    .mq_avail (mq_avail),
    .mq_pull  (mq_pull),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [64:0] mdl[$];
  logic [64:0] exp_q[$];
  logic [31:0] m_int;
  logic [15:0] m_cnt;
  logic [15:0] m_add;
  logic        m_ovf;
  logic [15:0] m_pcnt;

  task automatic chk(input string nm, input logic [64:0] act,
                     input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_exp(input logic [3:0] adr);
    int lvl;
    lvl = mdl.size();
    case (adr)
      4'd1: return m_int;
      4'd2: return {m_cnt, m_add};
      4'd4: return (32'(m_ovf) << 16) | (32'(lvl == 0) << 9)
                 | (32'(lvl == DEPTH) << 8) | 32'(lvl);
      4'd5: return 32'(m_pcnt);
      default: return 32'd0;
    endcase
  endfunction

  task automatic mdl_clear();
    mdl.delete();
    exp_q.delete();
    m_int  = '0;
    m_cnt  = '0;
    m_add  = '0;
    m_ovf  = 1'b0;
    m_pcnt = '0;
  endtask

  // Applies one bus cycle to the reference model at the clock edge.
  task automatic mdl_upd(input logic cyc, input logic stb,
                         input logic we, input logic [3:0] adr,
                         input logic [31:0] dat, input logic pull);
    logic w;
    logic pop;
    logic [64:0] cmd;
    w   = cyc & stb & we;
    pop = pull && (mdl.size() > 0);
    if (w && adr == 4'd0) begin
      mdl.delete();
      exp_q.delete();
      return;
    end
    if (pop) void'(mdl.pop_front());
    if (w && adr == 4'd3) begin
      if (mdl.size() < DEPTH) begin
        cmd = {dat[0], m_int, m_cnt, m_add};
        mdl.push_back(cmd);
        exp_q.push_back(cmd);
        m_pcnt = m_pcnt + 16'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (w && adr == 4'd1) m_int = dat;
    if (w && adr == 4'd2) begin
      m_cnt = dat[31:16];
      m_add = dat[15:0];
    end
    if (w && adr == 4'd4) m_ovf = 1'b0;
  endtask

  task automatic step(input logic cyc, input logic stb,
                      input logic we, input logic [3:0] adr,
                      input logic [31:0] dat, input logic pull);
    wb_cyc_i = cyc;
    wb_stb_i = stb;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    mq_pull  = pull;
    @(negedge clk);
    if (cyc && stb && !we) begin
      chk($sformatf("read_adr%0d", adr), 65'(wb_dat_o),
          65'(rd_exp(adr)));
    end
    chk("ack", 65'(wb_ack_o), 65'd1);
    @(posedge clk);
    mdl_upd(cyc, stb, we, adr, dat, pull);
    #1;
  endtask

  task automatic wr_(input logic [3:0] adr, input logic [31:0] dat,
                     input logic pull);
    step(1'b1, 1'b1, 1'b1, adr, dat, pull);
  endtask

  task automatic rd_(input logic [3:0] adr);
    step(1'b1, 1'b1, 1'b0, adr, 32'd0, 1'b0);
  endtask

  task automatic idle(input logic pull);
    step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, pull);
  endtask

  // Scoreboard monitor: checks the presented head, pops on pull.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("avail", 65'(mq_avail), 65'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
        chk("empty_data", mq_data, 65'd0);
      end else begin
        chk("head", mq_data, exp_q[0]);
        if (mq_pull) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0]  adr;
    logic [31:0] dat;
    int          r;
    rst_n    = 1'b0;
    mq_pull  = 1'b0;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    mdl_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_avail", 65'(mq_avail), 65'd0);
    chk("rst_data", mq_data, 65'd0);
    rst_n = 1'b1;

    // Single command round trip.
    wr_(4'd1, 32'h0000_1000, 1'b0);
    wr_(4'd2, 32'h0003_FFF0, 1'b0);
    wr_(4'd3, 32'd1, 1'b0);
    chk("t1_avail", 65'(mq_avail), 65'd1);
    chk("t1_data", mq_data,
        {1'b1, 32'h0000_1000, 16'h0003, 16'hFFF0});
    rd_(4'd4);
    rd_(4'd1);
    rd_(4'd2);

    // Overflow on the fifth push, then clear.
    wr_(4'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wr_(4'd1, 32'(i + 1), 1'b0);
      wr_(4'd3, 32'(i), 1'b0);
    end
    rd_(4'd4);
    rd_(4'd5);
    chk("t2_ovf", 65'(rd_exp(4'd4)), 65'h0001_0104);
    wr_(4'd4, 32'hFFFF_FFFF, 1'b0);
    rd_(4'd4);

    // Full FIFO: push with pull is accepted.
    wr_(4'd1, 32'h55, 1'b0);
    wr_(4'd3, 32'd0, 1'b1);
    rd_(4'd4);
    rd_(4'd5);

    // Ordered drain, then pull while empty.
    wr_(4'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      wr_(4'd1, 32'(i * 10), 1'b0);
      wr_(4'd3, 32'd0, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("t4_empty", 65'(mq_avail), 65'd0);
    idle(1'b1);
    rd_(4'd4);

    // Wrap-around with push/pull pairs.
    for (int i = 0; i < 10; i++) begin
      wr_(4'd1, 32'(100 + i), 1'b0);
      wr_(4'd3, 32'(i), 1'b1);
    end
    rd_(4'd4);

    // Flush beats a same-cycle pull; staging survives.
    wr_(4'd0, 32'd0, 1'b0);
    wr_(4'd2, 32'hABCD_1234, 1'b0);
    for (int i = 0; i < 3; i++) wr_(4'd3, 32'd1, 1'b0);
    rd_(4'd4);
    wr_(4'd0, 32'd0, 1'b1);
    chk("t6_avail", 65'(mq_avail), 65'd0);
    rd_(4'd4);
    rd_(4'd2);

    // Asynchronous reset mid-stream.
    wr_(4'd3, 32'd0, 1'b0);
    wr_(4'd3, 32'd1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_avail", 65'(mq_avail), 65'd0);
    chk("arst_data", mq_data, 65'd0);
    mdl_clear();
    #1 rst_n = 1'b1;
    rd_(4'd5);
    rd_(4'd2);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       adr = 4'd3;
      else if (r < 8)  adr = 4'd1;
      else if (r < 10) adr = 4'd2;
      else if (r < 12) adr = 4'd4;
      else if (r < 13) adr = 4'd5;
      else if (r < 14) adr = 4'd0;
      else             adr = 4'($urandom_range(0, 15));
      dat = $urandom;
      step(1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 3) != 0),
           adr, dat,
           1'($urandom_range(0, 2) == 0));
    end
    idle(1'b0);
    rd_(4'd4);
    rd_(4'd5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stepcmd_queue.md
Name: stepcmd_queue

Overview:
- Producer end of the step-command message queue: the wishbone side of the host stages step commands here, and the step scheduler pulls them in order.
- Holds a DEPTH-entry first-word-fall-through FIFO of 65-bit commands {dir, interval[31:0], count[15:0], add[15:0]}.
- Sits between the wishbone bus and the scheduler's mq_data/mq_avail/mq_pull inputs, on the same wishbone strobe as the scheduler.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mq_data  output  65  head entry {dir, interval, count, add}; 0 when empty.
- mq_avail  output  1  FIFO non-empty.
- mq_pull  input  1  consumer pops the head this cycle.
- wb_stb_i  input  1  wishbone strobe.
- wb_cyc_i  input  1  wishbone cycle.
- wb_we_i  input  1  wishbone write enable.
- wb_adr_i  input  4  word address.
- wb_dat_i  input  32  write data.
- wb_dat_o  output  32  read data, combinational.
- wb_ack_o  output  1  tied to 1; every access completes in a single cycle.

Behaviour:
- Definitions: wr = cyc & stb & we; rd = cyc & stb & !we.
- Reset (rst_n low, async) clears:
  - read/write pointers, level, overflow flag, push counter;
  - staging registers (st_interval, st_count, st_add).
  - Outputs after reset: mq_avail=0, mq_data=0.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Write map:
  - adr 0: flush. Level becomes 0, pointers equalize, staging unchanged. The scheduler treats the same write as its clock reset.
  - adr 1: st_interval <= dat[31:0].
  - adr 2: st_count <= dat[31:16]; st_add <= dat[15:0].
  - adr 3: push {dat[0], st_interval, st_count, st_add}. Staging registers are unchanged, so repeated pushes repeat the command.
  - adr 4: clears the overflow flag; data ignored.
  - All other addresses: ignored.
- Read map:
  - adr 4: {15'b0, overflow, 6'b0, empty, full, 3'b0, level[4:0]}.
  - adr 5: {16'b0, push_count[15:0]}.
  - adr 1: st_interval.
  - adr 2: {st_count, st_add}.
  - All other addresses: 0.
  - rd has no side effects.
- Push accept rule: accepted when level < DEPTH, or when mq_pull is valid in the same cycle.
  - Accepted push: writes mem[wptr], then wptr+1 (wraps mod DEPTH) and push_count+1 (wraps at 16 bits).
  - Rejected push (full and no pull): entry dropped, overflow <= 1 (sticky), push_count unchanged.
- Pull rule: mq_pull is honoured only when level > 0; rptr+1 (wraps mod DEPTH). mq_pull while empty is ignored.
- Simultaneous push and pull: level unchanged, both pointers advance. This includes level==DEPTH and level==1.
- Flush has priority over a same-cycle mq_pull: the pulled entry is discarded with the rest. This matches the scheduler, which also ignores the pull in that cycle.
- Latency:
  - A pushed entry appears on mq_data/mq_avail the cycle after the write edge.
  - After a pull, the next head appears the following cycle.
- Derived status: full = (level == DEPTH); empty = (level == 0); level ranges 0..DEPTH.

Test Plan:
- Reset, then write adr1 = 0x00001000, adr2 = 0x0003FFF0, adr3 = 1 → next cycle mq_avail=1 and mq_data = {1, 0x00001000, 0x0003, 0xFFF0}; adr4 read gives level 1.
- Five pushes with DEPTH=4 and no pulls → level=4, full=1; the fifth push is dropped, overflow=1, push_count=4. Write adr4 → overflow=0.
- Full FIFO, push and mq_pull in the same cycle → push accepted, level stays 4, push_count increments, head advances to entry 2.
- Push entries A, B, C with distinct intervals 10, 20, 30; pull three times in consecutive cycles → mq_data shows 10, 20, 30 in order, then mq_avail=0 and mq_data=0. A pull while empty leaves level at 0.
- Wrap-around: 10 push/pull pairs through DEPTH=4 → FIFO order preserved and the pointers wrap correctly.
- Level 3, write adr0 with mq_pull=1 in the same cycle → level=0, mq_avail=0, staging intact. Asserting rst_n low mid-stream clears the FIFO asynchronously.
